// File: rtl/pipe_stage_handshake_reg.sv
// pipe_stage_handshake_reg
// Generic valid/ready pipeline stage register with flush, bubble load on
// empty and a saturating head-entry stall counter.
// Optional feature macro: PIPE_STAGE_SKID_EN
//   defined   -> 2-entry skid buffer, o_ready comes straight from a flop
//   undefined -> single head register, o_ready = !o_valid | i_ready
module pipe_stage_handshake_reg #(
  parameter int                 WIDTH        = 32,
  parameter logic [WIDTH-1:0]   RST_VALUE    = {WIDTH{1'b0}},
  parameter logic [WIDTH-1:0]   BUBBLE_VALUE = {WIDTH{1'b0}},
  parameter int                 CNT_W        = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_flush,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic [CNT_W-1:0] o_stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic acc;
  logic pop;

  // Incoming data is dropped whenever a flush is requested.
  assign acc = i_valid & o_ready & ~i_flush;
  assign pop = o_valid & i_ready;

`ifdef PIPE_STAGE_SKID_EN

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t           state;
  logic             s_valid;
  logic [WIDTH-1:0] s_data;

  // Ready is only the inverse of the skid-occupied flop, so it never
  // depends on i_ready within the same cycle.
  assign o_ready = ~s_valid;

  // Three-state occupancy machine owning the head (M) and skid (S) registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_EMPTY;
      o_valid <= 1'b0;
      o_data  <= RST_VALUE;
      s_valid <= 1'b0;
      s_data  <= {WIDTH{1'b0}};
    end else if (i_flush) begin
      state   <= ST_EMPTY;
      o_valid <= 1'b0;
      o_data  <= BUBBLE_VALUE;
      s_valid <= 1'b0;
      s_data  <= {WIDTH{1'b0}};
    end else begin
      case (state)
        ST_EMPTY: begin
          if (acc) begin
            state   <= ST_ONE;
            o_valid <= 1'b1;
            o_data  <= i_data;
          end
        end
        ST_ONE: begin
          if (acc && pop) begin
            o_data <= i_data;
          end else if (acc) begin
            state   <= ST_TWO;
            s_valid <= 1'b1;
            s_data  <= i_data;
          end else if (pop) begin
            state   <= ST_EMPTY;
            o_valid <= 1'b0;
            o_data  <= BUBBLE_VALUE;
          end
        end
        ST_TWO: begin
          if (pop) begin
            state   <= ST_ONE;
            o_data  <= s_data;
            s_valid <= 1'b0;
            s_data  <= {WIDTH{1'b0}};
          end
        end
        default: begin
          state   <= ST_EMPTY;
          o_valid <= 1'b0;
          o_data  <= BUBBLE_VALUE;
          s_valid <= 1'b0;
          s_data  <= {WIDTH{1'b0}};
        end
      endcase
    end
  end

`else

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_ONE   = 1'b1
  } state_t;

  state_t state;

  // Without a skid slot the stage can take new data whenever the head is
  // empty or leaving this cycle, which makes ready combinational on i_ready.
  assign o_ready = ~o_valid | i_ready;

  // Two-state machine owning the single head register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_EMPTY;
      o_valid <= 1'b0;
      o_data  <= RST_VALUE;
    end else if (i_flush) begin
      state   <= ST_EMPTY;
      o_valid <= 1'b0;
      o_data  <= BUBBLE_VALUE;
    end else if (state == ST_EMPTY) begin
      if (acc) begin
        state   <= ST_ONE;
        o_valid <= 1'b1;
        o_data  <= i_data;
      end
    end else begin
      if (acc) begin
        o_data <= i_data;
      end else if (pop) begin
        state   <= ST_EMPTY;
        o_valid <= 1'b0;
        o_data  <= BUBBLE_VALUE;
      end
    end
  end

`endif

  // Saturating count of consecutive stalled cycles for the current head;
  // any pop (including a refill from the skid slot) restarts it at zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_stall_cnt <= {CNT_W{1'b0}};
    end else if (i_flush || pop) begin
      o_stall_cnt <= {CNT_W{1'b0}};
    end else if (o_valid && !i_ready && (o_stall_cnt != CNT_MAX)) begin
      o_stall_cnt <= o_stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_stage_handshake_reg.sv
// Testbench for pipe_stage_handshake_reg: directed steps followed by random
// traffic, compared against a queue-based reference model.
module tb_pipe_stage_handshake_reg;

  localparam int          WIDTH  = 8;
  localparam int          CNT_W  = 8;
  localparam logic [7:0]  RSTV   = 8'h5A;
  localparam logic [7:0]  BUBV   = 8'hB0;
  localparam int          CMAX   = 255;

  logic             clk;
  logic             reset;
  logic             i_valid;
  logic             o_ready;
  logic [WIDTH-1:0] i_data;
  logic             i_flush;
  logic             o_valid;
  logic             i_ready;
  logic [WIDTH-1:0] o_data;
  logic [CNT_W-1:0] o_stall_cnt;

  int vectors;
  int miscompares;

  logic [7:0]  mq[$];
  logic [7:0]  m_data;
  int          m_cnt;

  pipe_stage_handshake_reg #(
    .WIDTH(WIDTH),
    .RST_VALUE(RSTV),
    .BUBBLE_VALUE(BUBV),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .i_valid(i_valid),
    .o_ready(o_ready),
    .i_data(i_data),
    .i_flush(i_flush),
    .o_valid(o_valid),
    .i_ready(i_ready),
    .o_data(o_data),
    .o_stall_cnt(o_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Capacity rule: two entries with the skid slot, otherwise one entry that
  // can be replaced when downstream takes it in the same cycle.
  function automatic bit modelReady();
`ifdef PIPE_STAGE_SKID_EN
    return mq.size() < 2;
`else
    return (mq.size() == 0) || (i_ready === 1'b1);
`endif
  endfunction

  task automatic modelReset();
    mq.delete();
    m_data = RSTV;
    m_cnt  = 0;
  endtask

  // Advance the model across one rising edge using the inputs now applied.
  task automatic modelStep();
    bit pop;
    bit acc;
    pop = (mq.size() > 0) && i_ready;
    acc = i_valid && modelReady() && !i_flush;
    if (i_flush) begin
      mq.delete();
      m_data = BUBV;
      m_cnt  = 0;
    end else begin
      if (pop) m_cnt = 0;
      else if (mq.size() > 0 && !i_ready) m_cnt = (m_cnt >= CMAX) ? CMAX : m_cnt + 1;
      if (pop) void'(mq.pop_front());
      if (acc) mq.push_back(i_data);
      if (mq.size() > 0) m_data = mq[0];
      else if (pop) m_data = BUBV;
    end
  endtask

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    checkEq("o_valid", {31'd0, o_valid}, {31'd0, mq.size() > 0});
    checkEq("o_data", {24'd0, o_data}, {24'd0, m_data});
    checkEq("o_stall_cnt", {24'd0, o_stall_cnt}, m_cnt);
    checkEq("o_ready", {31'd0, o_ready}, {31'd0, modelReady()});
  endtask

  // Drive one cycle's inputs after the falling edge, check, then step model.
  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic f, input logic r);
    @(negedge clk);
    i_valid = v;
    i_data  = d;
    i_flush = f;
    i_ready = r;
    #1;
    checkOutput();
    modelStep();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset   = 1'b1;
    i_valid = 1'b0;
    i_data  = '0;
    i_flush = 1'b0;
    i_ready = 1'b0;
    modelReset();
    #3;
    checkOutput();
    checkEq("reset_data", {24'd0, o_data}, {24'd0, RSTV});
    @(negedge clk);
    reset = 1'b0;

    // Streaming with downstream always ready.
    applyStimulus(1'b1, 8'h11, 1'b0, 1'b1);
    applyStimulus(1'b1, 8'h22, 1'b0, 1'b1);
    checkEq("stream_0x11", {24'd0, o_data}, 32'h11);
    applyStimulus(1'b1, 8'h33, 1'b0, 1'b1);
    checkEq("stream_0x22", {24'd0, o_data}, 32'h22);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkEq("stream_0x33", {24'd0, o_data}, 32'h33);
    checkEq("stream_cnt", {24'd0, o_stall_cnt}, 32'd0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkEq("drain_bubble", {24'd0, o_data}, {24'd0, BUBV});

`ifdef PIPE_STAGE_SKID_EN
    // Two accepts into a stalled stage fill the skid slot.
    applyStimulus(1'b1, 8'h0A, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h0B, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkEq("skid_ready_low", {31'd0, o_ready}, 32'd0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkEq("skid_pop_a", {24'd0, o_data}, 32'h0A);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkEq("skid_pop_b", {24'd0, o_data}, 32'h0B);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkEq("skid_empty", {31'd0, o_valid}, 32'd0);
    checkEq("skid_bubble", {24'd0, o_data}, {24'd0, BUBV});
`else
    // Full head with downstream ready still accepts in the same cycle.
    applyStimulus(1'b1, 8'h44, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h55, 1'b0, 1'b1);
    checkEq("replace_ready", {31'd0, o_ready}, 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkEq("replace_data", {24'd0, o_data}, 32'h55);
    checkEq("replace_valid", {31'd0, o_valid}, 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
`endif

    // Long stall: counter saturates, then clears on the pop.
    applyStimulus(1'b1, 8'h66, 1'b0, 1'b0);
    for (int i = 0; i < 300; i++) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkEq("stall_sat", {24'd0, o_stall_cnt}, 32'd255);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkEq("stall_clear", {24'd0, o_stall_cnt}, 32'd0);

    // Flush a full stage while a new word is offered.
    applyStimulus(1'b1, 8'h77, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h88, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h0C, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkEq("flush_valid", {31'd0, o_valid}, 32'd0);
    checkEq("flush_data", {24'd0, o_data}, {24'd0, BUBV});
    checkEq("flush_ready", {31'd0, o_ready}, 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkEq("flush_no_0c", {24'd0, o_data}, {24'd0, BUBV});

    // Asynchronous reset between edges while holding entries.
    applyStimulus(1'b1, 8'h91, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h92, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    #2;
    reset   = 1'b1;
    i_valid = 1'b0;
    #1;
    modelReset();
    checkOutput();
    checkEq("areset_data", {24'd0, o_data}, {24'd0, RSTV});
    #1;
    reset = 1'b0;

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 8'($urandom),
                    ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) < 6));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
